// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/slave pair: FSM state encodings,
// bit-counter width and the default synchronizer depth.
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  // Bit counter width; covers TRANSFER_SIZE up to 4095.
  localparam int SPI_CNT_W = 12;

  // Default number of flops in each external-input synchronizer.
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous input, followed by rise/fall
// detection of the synchronized level against a registered copy.
//
// Parameters:
//   STAGES        number of synchronizer flops (>= 2)
//   RST_VAL       reset value of the registered copy used for edge detection
//   CHAIN_RST_VAL reset value of the synchronizer flops themselves
// Ports:
//   clk_in    system clock
//   rst_in    asynchronous active-high reset
//   async_in  raw asynchronous input
//   sync_out  synchronized level (last synchronizer stage)
//   rise_out  synchronized level went 0 -> 1 this cycle
//   fall_out  synchronized level went 1 -> 0 this cycle
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES        = 2,
  parameter logic RST_VAL       = 1'b1,
  parameter logic CHAIN_RST_VAL = RST_VAL
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out,
  output logic rise_out,
  output logic fall_out
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= {STAGES{CHAIN_RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise_out =  sync_q[STAGES-1] & ~prev_q;
  assign fall_out = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder. Oversamples SCS/SCK/SDI on clk_in, shifts in a
// TRANSFER_SIZE-bit word MSB-first while shifting out a preloaded reply word,
// presents the received word with a one-cycle valid strobe and flags aborted
// or overlong frames with a one-cycle error strobe.
//
// Parameters:
//   TRANSFER_SIZE  bits per frame (2..4095)
//   SPI_POLARITY   SCK idle level; SDI is sampled on the edge toward it
//   SYNC_STAGES    synchronizer depth for each SPI input (>= 2)
// Ports:
//   clk_in, rst_in      system clock, asynchronous active-high reset
//   tx_data_in          reply word for the next frame
//   tx_load_in          latch tx_data_in (ignored while busy_out=1)
//   rx_data_out         last complete received word
//   rx_valid_out        one-cycle pulse when rx_data_out updates
//   busy_out            frame in progress
//   error_out           one-cycle pulse on aborted or overlong frame
//   spi_scs_in          chip select, active-low
//   spi_sck_in          serial clock
//   spi_sdi_in          data from master
//   spi_sdo_out         data to master
//   spi_sdo_oe_out      SDO output enable (only with SPI_SLAVE_SDO_TRISTATE_EN)
//
// Build option: define SPI_SLAVE_SDO_TRISTATE_EN to add spi_sdo_oe_out so
// several slaves can share one MISO line; SDO then holds its last value while
// not enabled instead of idling high.
// -----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int   TRANSFER_SIZE = 8,
  parameter logic SPI_POLARITY  = 1'b1,
  parameter int   SYNC_STAGES   = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [TRANSFER_SIZE-1:0] tx_data_in,
  input  logic                     tx_load_in,
  output logic [TRANSFER_SIZE-1:0] rx_data_out,
  output logic                     rx_valid_out,
  output logic                     busy_out,
  output logic                     error_out,
  input  logic                     spi_scs_in,
  input  logic                     spi_sck_in,
  input  logic                     spi_sdi_in,
  output logic                     spi_sdo_out
`ifdef SPI_SLAVE_SDO_TRISTATE_EN
  ,
  output logic                     spi_sdo_oe_out
`endif
);

  localparam logic [SPI_CNT_W-1:0] CNT_INIT = SPI_CNT_W'(TRANSFER_SIZE);

  logic scs_sync, scs_rise, scs_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic sdi_sync;
  logic unused_scs_sync_lvl, unused_sck_sync, unused_sdi_rise, unused_sdi_fall;

  // The SCS chain resets to 0 (deasserted would be 1) so that a chip select
  // held low across reset is never mistaken for a fresh falling edge: a frame
  // is only accepted after SCS has been seen high (scs_armed).
  spi_sync_edge #(
    .STAGES        (SYNC_STAGES),
    .RST_VAL       (1'b1),
    .CHAIN_RST_VAL (1'b0)
  ) u_sync_scs (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (spi_scs_in),
    .sync_out (scs_sync),
    .rise_out (scs_rise),
    .fall_out (scs_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SPI_POLARITY)
  ) u_sync_sck (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (spi_sck_in),
    .sync_out (sck_sync),
    .rise_out (sck_rise),
    .fall_out (sck_fall)
  );

  // SDI travels through the same depth as SCK so data and clock stay aligned.
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_sdi (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .async_in (spi_sdi_in),
    .sync_out (sdi_sync),
    .rise_out (unused_sdi_rise),
    .fall_out (unused_sdi_fall)
  );

  assign unused_scs_sync_lvl = scs_sync;
  assign unused_sck_sync     = sck_sync;

  logic sample_edge;
  assign sample_edge = SPI_POLARITY ? sck_rise : sck_fall;

  spi_state_e               state;
  logic [SPI_CNT_W-1:0]     bit_cnt;
  logic [TRANSFER_SIZE-1:0] shift_reg;
  logic [TRANSFER_SIZE-1:0] tx_shadow;
  logic                     scs_armed;
  logic                     overlong_flagged;
  logic                     sdo_oe;

  logic [TRANSFER_SIZE-1:0] shift_next;
  logic [TRANSFER_SIZE-1:0] start_word;

  assign shift_next = {shift_reg[TRANSFER_SIZE-2:0], sdi_sync};
  // A load coinciding with the SCS fall is used for the frame that starts.
  assign start_word = tx_load_in ? tx_data_in : tx_shadow;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      tx_shadow        <= '0;
      rx_data_out      <= '0;
      rx_valid_out     <= 1'b0;
      busy_out         <= 1'b0;
      error_out        <= 1'b0;
      spi_sdo_out      <= 1'b1;
      scs_armed        <= 1'b0;
      overlong_flagged <= 1'b0;
      sdo_oe           <= 1'b0;
    end else begin
      rx_valid_out <= 1'b0;
      error_out    <= 1'b0;
      if (scs_sync) scs_armed <= 1'b1;

      case (state)
        IDLE: begin
          if (tx_load_in) tx_shadow <= tx_data_in;
          if (scs_fall && scs_armed) begin
            state            <= SHIFT;
            bit_cnt          <= CNT_INIT;
            shift_reg        <= start_word;
            busy_out         <= 1'b1;
            spi_sdo_out      <= start_word[TRANSFER_SIZE-1];
            overlong_flagged <= 1'b0;
            sdo_oe           <= 1'b1;
          end
        end

        SHIFT: begin
          // SCS release wins over a coincident sample edge.
          if (scs_rise) begin
            error_out <= 1'b1;
            state     <= IDLE;
            busy_out  <= 1'b0;
            sdo_oe    <= 1'b0;
`ifndef SPI_SLAVE_SDO_TRISTATE_EN
            spi_sdo_out <= 1'b1;
`endif
          end else if (sample_edge) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt - 1'b1;
            if (bit_cnt == SPI_CNT_W'(1)) begin
              rx_data_out  <= shift_next;
              rx_valid_out <= 1'b1;
              state        <= DONE;
              spi_sdo_out  <= 1'b1;
            end else begin
              spi_sdo_out <= shift_reg[TRANSFER_SIZE-2];
            end
          end
        end

        DONE: begin
          if (scs_rise) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            sdo_oe   <= 1'b0;
          end else if (sample_edge && !overlong_flagged) begin
            error_out        <= 1'b1;
            overlong_flagged <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_SDO_TRISTATE_EN
  assign spi_sdo_oe_out = sdo_oe;
`else
  logic unused_sdo_oe;
  assign unused_sdo_oe = sdo_oe;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Self-checking bench for spi_slave (TRANSFER_SIZE=8, SPI_POLARITY=1,
// SYNC_STAGES=2). The bench acts as SPI master with a half-period of H clk_in
// cycles: SDI is driven and SDO read while SCK is low, the slave samples on
// the rising edge. A table of frames drives the main checks; reset behaviour
// and a mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int N = 8;
  localparam int H = 6;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [N-1:0] tx_data_in = '0;
  logic         tx_load_in = 1'b0;
  logic [N-1:0] rx_data_out;
  logic         rx_valid_out;
  logic         busy_out;
  logic         error_out;
  logic         spi_scs_in = 1'b1;
  logic         spi_sck_in = 1'b1;
  logic         spi_sdi_in = 1'b0;
  logic         spi_sdo_out;
`ifdef SPI_SLAVE_SDO_TRISTATE_EN
  logic         spi_sdo_oe_out;
`endif

  spi_slave #(
    .TRANSFER_SIZE (N),
    .SPI_POLARITY  (1'b1),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .tx_data_in   (tx_data_in),
    .tx_load_in   (tx_load_in),
    .rx_data_out  (rx_data_out),
    .rx_valid_out (rx_valid_out),
    .busy_out     (busy_out),
    .error_out    (error_out),
    .spi_scs_in   (spi_scs_in),
    .spi_sck_in   (spi_sck_in),
    .spi_sdi_in   (spi_sdi_in),
    .spi_sdo_out  (spi_sdo_out)
`ifdef SPI_SLAVE_SDO_TRISTATE_EN
    ,
    .spi_sdo_oe_out (spi_sdo_oe_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int tests_run = 0;
  int tests_failed = 0;

  // Pulse monitor: running totals sampled on the inactive edge.
  int vld_total = 0;
  int err_total = 0;
  always @(negedge clk_in) begin
    if (rx_valid_out) vld_total++;
    if (error_out)    err_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // ld_mode: 0 none, 1 load while idle before the frame,
  //          2 load in the cycle the slave sees the SCS fall,
  //          3 load attempt while busy (during bit 2)
  task automatic do_frame(input logic [N-1:0] mosi, input int nbits,
                          input int ld_mode, input logic [N-1:0] ld_word,
                          output logic [N-1:0] miso, output logic busy_mid);
    miso     = '0;
    busy_mid = 1'b0;
    if (ld_mode == 1) begin
      tx_data_in = ld_word; tx_load_in = 1'b1;
      wait_neg(1);
      tx_load_in = 1'b0;
      wait_neg(1);
    end
    spi_scs_in = 1'b0;
    if (ld_mode == 2) begin
      // SCS fall reaches the FSM on the third rising clk edge after the change.
      wait_neg(2);
      tx_data_in = ld_word; tx_load_in = 1'b1;
      wait_neg(1);
      tx_load_in = 1'b0;
      wait_neg(H - 3);
    end else begin
      wait_neg(H);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_sck_in = 1'b0;
      spi_sdi_in = (i < N) ? mosi[N-1-i] : 1'b0;
      if (ld_mode == 3 && i == 2) begin
        tx_data_in = ld_word; tx_load_in = 1'b1;
        wait_neg(1);
        tx_load_in = 1'b0;
        wait_neg(H - 1);
      end else begin
        wait_neg(H);
      end
      if (i < N) miso[N-1-i] = spi_sdo_out;
      if (i == 2) busy_mid = busy_out;
      spi_sck_in = 1'b1;
      wait_neg(H);
    end
    wait_neg(H);
    spi_scs_in = 1'b1;
    wait_neg(H);
  endtask

  typedef struct {
    int           ld_mode;
    logic [N-1:0] ld_word;
    logic [N-1:0] mosi;
    int           nbits;
    int           exp_vld;
    int           exp_err;
    logic [N-1:0] exp_rx;
    logic [N-1:0] exp_miso;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [N-1:0] miso;
    logic         busy_mid;
    int           v0, e0;

    //               mode  ld     mosi   bits vld err rx     miso
    vecs[0]  = '{1, 8'hA5, 8'h3C, 8,  1, 0, 8'h3C, 8'hA5};  // basic loopback
    vecs[1]  = '{1, 8'h81, 8'hFF, 8,  1, 0, 8'hFF, 8'h81};  // all ones
    vecs[2]  = '{1, 8'h81, 8'h00, 8,  1, 0, 8'h00, 8'h81};  // all zeros
    vecs[3]  = '{0, 8'h00, 8'h96, 5,  0, 1, 8'h00, 8'h80};  // aborted after 5 bits
    vecs[4]  = '{0, 8'h00, 8'h5A, 8,  1, 0, 8'h5A, 8'h81};  // recovery after abort
    vecs[5]  = '{1, 8'hC3, 8'h12, 9,  1, 1, 8'h12, 8'hC3};  // one extra bit
    vecs[6]  = '{1, 8'h0F, 8'hE7, 10, 1, 1, 8'hE7, 8'h0F};  // two extra bits, one error
    vecs[7]  = '{1, 8'h01, 8'h80, 8,  1, 0, 8'h80, 8'h01};
    vecs[8]  = '{3, 8'h55, 8'h33, 8,  1, 0, 8'h33, 8'h01};  // load while busy ignored
    vecs[9]  = '{0, 8'h00, 8'h44, 8,  1, 0, 8'h44, 8'h01};  // shadow still 01
    vecs[10] = '{2, 8'h6B, 8'h77, 8,  1, 0, 8'h77, 8'h6B};  // load on SCS fall used
    vecs[11] = '{1, 8'h00, 8'hFF, 8,  1, 0, 8'hFF, 8'h00};

    // Reset state, sampled while reset is held.
    wait_neg(3);
    check("rst_rx_data",  32'(rx_data_out),  32'h0);
    check("rst_rx_valid", 32'(rx_valid_out), 32'h0);
    check("rst_busy",     32'(busy_out),     32'h0);
    check("rst_error",    32'(error_out),    32'h0);
    check("rst_sdo",      32'(spi_sdo_out),  32'h1);
    rst_in = 1'b0;
    wait_neg(10);

    for (int k = 0; k < 12; k++) begin
      v0 = vld_total; e0 = err_total;
      do_frame(vecs[k].mosi, vecs[k].nbits, vecs[k].ld_mode, vecs[k].ld_word, miso, busy_mid);
      check($sformatf("v%0d_valid_pulses", k), 32'(vld_total - v0), 32'(vecs[k].exp_vld));
      check($sformatf("v%0d_error_pulses", k), 32'(err_total - e0), 32'(vecs[k].exp_err));
      check($sformatf("v%0d_rx_data", k),      32'(rx_data_out),    32'(vecs[k].exp_rx));
      check($sformatf("v%0d_miso", k),         32'(miso),           32'(vecs[k].exp_miso));
      check($sformatf("v%0d_busy_mid", k),     32'(busy_mid),       32'h1);
      check($sformatf("v%0d_idle_busy_sdo", k), 32'({busy_out, spi_sdo_out}), 32'h1);
    end

    // Reset in the middle of a frame after 3 bits; the rest of that frame
    // must produce nothing, and a fresh frame must then work.
    v0 = vld_total; e0 = err_total;
    spi_scs_in = 1'b0;
    wait_neg(H);
    for (int i = 0; i < 3; i++) begin
      spi_sck_in = 1'b0; spi_sdi_in = i[0];
      wait_neg(H);
      spi_sck_in = 1'b1;
      wait_neg(H);
    end
    rst_in = 1'b1;
    wait_neg(1);
    check("midrst_rx_data", 32'(rx_data_out), 32'h0);
    check("midrst_busy",    32'(busy_out),    32'h0);
    check("midrst_sdo",     32'(spi_sdo_out), 32'h1);
    check("midrst_flags",   32'({rx_valid_out, error_out}), 32'h0);
    wait_neg(1);
    rst_in = 1'b0;
    for (int i = 3; i < N; i++) begin
      spi_sck_in = 1'b0; spi_sdi_in = 1'b1;
      wait_neg(H);
      check($sformatf("midrst_busy_b%0d", i), 32'(busy_out), 32'h0);
      spi_sck_in = 1'b1;
      wait_neg(H);
    end
    wait_neg(H);
    spi_scs_in = 1'b1;
    wait_neg(H);
    check("midrst_no_valid", 32'(vld_total - v0), 32'h0);
    check("midrst_no_error", 32'(err_total - e0), 32'h0);

    v0 = vld_total; e0 = err_total;
    do_frame(8'h2D, 8, 1, 8'h9C, miso, busy_mid);
    check("postrst_valid", 32'(vld_total - v0), 32'h1);
    check("postrst_error", 32'(err_total - e0), 32'h0);
    check("postrst_rx",    32'(rx_data_out),    32'h2D);
    check("postrst_miso",  32'(miso),           32'h9C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
